iss_muldiv_unit: RTL and testbench

Iterative RV32M/RV64M multiply-divide execute unit for the ISS datapath. It sits beside the single-cycle ALU and takes the eight M-extension operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) from the decode stage. It uses a request/response valid-ready handshake and computes one radix-2 step per cycle. Operand width is parametrised, and the unit supports in-flight kill.

---
 rtl/iss_muldiv_unit.sv | 222 ++++++++++++++++++++++
 tb/tb_iss_muldiv_unit.sv | 498 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iss_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: one radix-2 step per cycle.
// Ports: clk, rst, req_{valid,ready,funct3,op1,op2,kill},
//        resp_{valid,ready,result}, busy.
module iss_muldiv_unit #(
    parameter  int XLEN  = 32,
    localparam int CNT_W = $clog2(XLEN + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_op1,
    input  logic [XLEN-1:0] req_op2,
    input  logic            req_kill,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_result,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam logic [XLEN-1:0] ONES    = '1;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [2:0]          f3;
    logic                neg_res;
    logic                neg_rem;
    // Multiply: acc = partial product, mcand = shifted multiplicand,
    // opb = remaining multiplier bits.
    // Divide: acc = {remainder, dividend/quotient}, opb = divisor.
    logic [2*XLEN-1:0]   acc;
    logic [2*XLEN-1:0]   mcand;
    logic [XLEN-1:0]     opb;

    // ---------------- request decode ----------------
    logic            op1_signed;
    logic            op2_signed;
    logic            s1;
    logic            s2;
    logic [XLEN-1:0] mag1;
    logic [XLEN-1:0] mag2;
    logic            div_zero;
    logic            div_ovf;
    logic            special;
    logic [XLEN-1:0] special_res;

    always_comb begin
        op1_signed = 1'b0;
        op2_signed = 1'b0;
        unique case (req_funct3)
            3'b001: begin
                op1_signed = 1'b1;
                op2_signed = 1'b1;
            end
            3'b010: op1_signed = 1'b1;
            3'b100, 3'b110: begin
                op1_signed = 1'b1;
                op2_signed = 1'b1;
            end
            default: ;
        endcase
    end

    assign s1   = op1_signed & req_op1[XLEN-1];
    assign s2   = op2_signed & req_op2[XLEN-1];
    // Two's complement of INT_MIN is INT_MIN, which reads
    // correctly as the unsigned magnitude 2^(XLEN-1).
    assign mag1 = s1 ? -req_op1 : req_op1;
    assign mag2 = s2 ? -req_op2 : req_op2;

    assign div_zero = req_funct3[2] & (req_op2 == '0);
    assign div_ovf  = req_funct3[2] & ~req_funct3[0]
                    & (req_op1 == INT_MIN) & (req_op2 == ONES);
    assign special  = div_zero | div_ovf;

    always_comb begin
        if (div_zero) begin
            special_res = req_funct3[1] ? req_op1 : ONES;
        end else begin
            special_res = req_funct3[1] ? '0 : req_op1;
        end
    end

    // ---------------- iteration step ----------------
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_hi;
    logic [XLEN-1:0]   div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] step_next;

    assign mul_next = acc + (opb[0] ? mcand : '0);

    // Shift {rem, quo} left one bit; the partial remainder gets
    // one extra bit so the compare never overflows.
    assign div_hi   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    assign div_ge   = div_hi >= {1'b0, opb};
    // When div_ge holds the true difference is below opb, so
    // XLEN-bit wraparound subtraction is exact.
    assign div_diff = div_hi[XLEN-1:0] - opb;
    assign div_next = div_ge
                    ? {div_diff, acc[XLEN-2:0], 1'b1}
                    : {acc[2*XLEN-2:0], 1'b0};

    assign step_next = f3[2] ? div_next : mul_next;

    // ---------------- final sign fix-up ----------------
    logic [2*XLEN-1:0] mul_prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   fin_res;

    always_comb begin
        mul_prod = neg_res ? -mul_next : mul_next;
        quo      = div_next[XLEN-1:0];
        rem      = div_next[2*XLEN-1:XLEN];
        fin_res  = '0;
        if (f3[2]) begin
            if (f3[1]) begin
                fin_res = neg_rem ? -rem : rem;
            end else begin
                fin_res = neg_res ? -quo : quo;
            end
        end else if (f3[1:0] == 2'b00) begin
            fin_res = mul_prod[XLEN-1:0];
        end else begin
            fin_res = mul_prod[2*XLEN-1:XLEN];
        end
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            f3          <= '0;
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
            acc         <= '0;
            mcand       <= '0;
            opb         <= '0;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_result <= '0;
            busy        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    // A kill in IDLE blocks a same-cycle request.
                    if (req_valid && !req_kill) begin
                        f3        <= req_funct3;
                        neg_res   <= s1 ^ s2;
                        neg_rem   <= s1;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (special) begin
                            resp_result <= special_res;
                            resp_valid  <= 1'b1;
                            state       <= DONE;
                        end else begin
                            cnt   <= CNT_W'(XLEN);
                            opb   <= mag2;
                            state <= CALC;
                            if (req_funct3[2]) begin
                                acc   <= {{XLEN{1'b0}}, mag1};
                                mcand <= '0;
                            end else begin
                                acc   <= '0;
                                mcand <= {{XLEN{1'b0}}, mag1};
                            end
                        end
                    end
                end
                CALC: begin
                    if (req_kill) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        acc   <= step_next;
                        mcand <= mcand << 1;
                        if (!f3[2]) begin
                            opb <= opb >> 1;
                        end
                        if (cnt == CNT_W'(1)) begin
                            cnt         <= '0;
                            resp_result <= fin_res;
                            resp_valid  <= 1'b1;
                            state       <= DONE;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (req_kill || resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iss_muldiv_unit.sv
// Self-checking bench for iss_muldiv_unit (XLEN=32 and XLEN=8 builds).
// Scoreboard queue of expected results, one task per scenario.
module tb_iss_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_op1;
    logic [31:0] req_op2;
    logic        req_kill;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_result;
    logic        busy;

    logic        s_req_valid;
    logic        s_req_ready;
    logic [2:0]  s_funct3;
    logic [7:0]  s_op1;
    logic [7:0]  s_op2;
    logic        s_kill;
    logic        s_resp_valid;
    logic        s_resp_ready;
    logic [7:0]  s_result;
    logic        s_busy;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    iss_muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_funct3(req_funct3), .req_op1(req_op1),
        .req_op2(req_op2), .req_kill(req_kill),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .busy(busy)
    );

    iss_muldiv_unit #(.XLEN(8)) dut8 (
        .clk(clk), .rst(rst),
        .req_valid(s_req_valid), .req_ready(s_req_ready),
        .req_funct3(s_funct3), .req_op1(s_op1),
        .req_op2(s_op2), .req_kill(s_kill),
        .resp_valid(s_resp_valid), .resp_ready(s_resp_ready),
        .resp_result(s_result), .busy(s_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] model(logic [2:0] f,
                                          logic [31:0] a,
                                          logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] p;
        logic ovf;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'b000: begin p = ua * ub; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                return $signed(a) / $signed(b);
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Drive one request; returns one cycle after the accept edge.
    task automatic issue(input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] e);
        req_funct3 = f;
        req_op1    = a;
        req_op2    = b;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op1   = $urandom;
        req_op2   = $urandom;
        exp_q.push_back(e);
    endtask

    // Waits for resp_valid; lat = cycle number after accept, -1 on timeout.
    task automatic wait_resp(output logic [31:0] res, output int lat,
                             output int busy_low);
        res = '0;
        busy_low = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (!busy) busy_low++;
            if (resp_valid) begin
                res = resp_result;
                lat = i;
                return;
            end
            @(posedge clk);
            #1;
        end
        lat = -1;
    endtask

    task automatic take();
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_req_ready: got %b want 1", req_ready);
        end
        n_vec++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: got valid=%b busy=%b want 0/0",
                     resp_valid, busy);
        end
        n_vec++;
        if (resp_result !== 32'h0) begin
            n_err++;
            $display("FAIL reset_result: got %h want 0", resp_result);
        end
        rst = 1'b0;
    endtask

    task automatic test_mul();
        logic [31:0] r;
        logic [31:0] e;
        int lat;
        int bl;
        issue(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        wait_resp(r, lat, bl);
        e = exp_q.pop_front();
        n_vec++;
        if (r !== e) begin
            n_err++;
            $display("FAIL mul_result: got %h want %h", r, e);
        end
        n_vec++;
        if (lat != 33) begin
            n_err++;
            $display("FAIL mul_latency: got %0d want 33", lat);
        end
        n_vec++;
        if (bl != 0) begin
            n_err++;
            $display("FAIL mul_busy: busy low in %0d cycles want 0", bl);
        end
        take();
    endtask

    task automatic test_directed();
        logic [2:0]  f[7] = '{3'b001, 3'b011, 3'b010, 3'b100,
                              3'b110, 3'b101, 3'b111};
        logic [31:0] a[7] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        logic [31:0] b[7] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] x[7] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                              32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        logic [31:0] r;
        logic [31:0] e;
        int lat;
        int bl;
        for (int i = 0; i < 7; i++) begin
            issue(f[i], a[i], b[i], x[i]);
            wait_resp(r, lat, bl);
            e = exp_q.pop_front();
            n_vec++;
            if (r !== e || lat != 33) begin
                n_err++;
                $display("FAIL directed_%0d: got %h lat %0d want %h lat 33",
                         i, r, lat, e);
            end
            take();
        end
    endtask

    task automatic test_special();
        logic [2:0]  f[4] = '{3'b100, 3'b111, 3'b100, 3'b110};
        logic [31:0] a[4] = '{32'd5, 32'd13, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] b[4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] x[4] = '{32'hFFFF_FFFF, 32'd13, 32'h8000_0000, 32'd0};
        logic [31:0] r;
        logic [31:0] e;
        int lat;
        int bl;
        for (int i = 0; i < 4; i++) begin
            issue(f[i], a[i], b[i], x[i]);
            wait_resp(r, lat, bl);
            e = exp_q.pop_front();
            n_vec++;
            if (r !== e || lat != 1) begin
                n_err++;
                $display("FAIL special_%0d: got %h lat %0d want %h lat 1",
                         i, r, lat, e);
            end
            take();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] r;
        logic [31:0] e;
        int lat;
        int bl;
        int bad;
        issue(3'b101, 32'd100, 32'd7, 32'd14);
        wait_resp(r, lat, bl);
        e = exp_q.pop_front();
        n_vec++;
        if (r !== e) begin
            n_err++;
            $display("FAIL bp_result: got %h want %h", r, e);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (resp_result !== e || req_ready !== 1'b0 ||
                resp_valid !== 1'b1) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL bp_hold: %0d unstable cycles want 0", bad);
        end
        take();
        @(negedge clk);
        n_vec++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release: got valid=%b ready=%b want 0/1",
                     resp_valid, req_ready);
        end
        issue(3'b111, 32'd100, 32'd7, 32'd2);
        wait_resp(r, lat, bl);
        e = exp_q.pop_front();
        n_vec++;
        if (r !== e || lat != 33) begin
            n_err++;
            $display("FAIL bp_second: got %h lat %0d want %h lat 33",
                     r, lat, e);
        end
        take();
    endtask

    task automatic test_kill();
        logic [31:0] r;
        logic [31:0] e;
        int lat;
        int bl;
        int stale;
        issue(3'b100, 32'h0123_4567, 32'd13, model(3'b100, 32'h0123_4567, 32'd13));
        repeat (9) @(posedge clk);
        #1;
        req_kill = 1'b1;
        @(posedge clk);
        #1;
        req_kill = 1'b0;
        void'(exp_q.pop_back());
        @(negedge clk);
        n_vec++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL kill_calc: got v=%b r=%b b=%b want 0/1/0",
                     resp_valid, req_ready, busy);
        end
        stale = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (resp_valid) stale++;
        end
        n_vec++;
        if (stale != 0) begin
            n_err++;
            $display("FAIL kill_stale: got %0d valid cycles want 0", stale);
        end
        // Kill while a special-case response waits in DONE.
        issue(3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF);
        req_kill = 1'b1;
        @(posedge clk);
        #1;
        req_kill = 1'b0;
        void'(exp_q.pop_back());
        @(negedge clk);
        n_vec++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL kill_done: got v=%b r=%b want 0/1",
                     resp_valid, req_ready);
        end
        // Kill in IDLE blocks a same-cycle request.
        req_funct3 = 3'b000;
        req_op1    = 32'd1;
        req_op2    = 32'd1;
        req_valid  = 1'b1;
        req_kill   = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_kill  = 1'b0;
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL kill_idle: got busy=%b ready=%b want 0/1",
                     busy, req_ready);
        end
        issue(3'b000, 32'd3, 32'd4, 32'd12);
        wait_resp(r, lat, bl);
        e = exp_q.pop_front();
        n_vec++;
        if (r !== e || lat != 33) begin
            n_err++;
            $display("FAIL kill_after: got %h lat %0d want %h lat 33",
                     r, lat, e);
        end
        take();
    endtask

    task automatic test_rst_abort();
        logic [31:0] r;
        logic [31:0] e;
        int lat;
        int bl;
        int stale;
        issue(3'b101, 32'hDEAD_BEEF, 32'd3, 32'hDEAD_BEEF / 32'd3);
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        void'(exp_q.pop_back());
        @(negedge clk);
        n_vec++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL rst_abort: got v=%b r=%b b=%b want 0/1/0",
                     resp_valid, req_ready, busy);
        end
        stale = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (resp_valid) stale++;
        end
        n_vec++;
        if (stale != 0) begin
            n_err++;
            $display("FAIL rst_stale: got %0d valid cycles want 0", stale);
        end
        issue(3'b000, 32'd3, 32'd4, 32'd12);
        wait_resp(r, lat, bl);
        e = exp_q.pop_front();
        n_vec++;
        if (r !== e || lat != 33) begin
            n_err++;
            $display("FAIL rst_after: got %h lat %0d want %h lat 33",
                     r, lat, e);
        end
        take();
    endtask

    task automatic test_random();
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [31:0] e;
        int lat;
        int bl;
        int xl;
        for (int i = 0; i < 24; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            if (i % 4 == 1) b = 32'($urandom_range(1, 15));
            if (i % 4 == 2) b = -32'($urandom_range(1, 15));
            if (i % 7 == 3) b = 32'd0;
            xl = (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 &&
                  b == 32'hFFFF_FFFF))) ? 1 : 33;
            issue(f, a, b, model(f, a, b));
            wait_resp(r, lat, bl);
            e = exp_q.pop_front();
            n_vec++;
            if (r !== e || lat != xl) begin
                n_err++;
                $display("FAIL random_%0d f3=%0d %h,%h: got %h lat %0d want %h lat %0d",
                         i, f, a, b, r, lat, e, xl);
            end
            take();
        end
    endtask

    task automatic test_xlen8();
        logic [2:0] f[2] = '{3'b100, 3'b000};
        logic [7:0] a[2] = '{8'h80, 8'h0F};
        logic [7:0] b[2] = '{8'hFF, 8'h11};
        logic [7:0] x[2] = '{8'h80, 8'hFF};
        int         l[2] = '{1, 9};
        logic [31:0] e;
        logic [7:0] r;
        int lat;
        for (int i = 0; i < 2; i++) begin
            s_funct3    = f[i];
            s_op1       = a[i];
            s_op2       = b[i];
            s_req_valid = 1'b1;
            @(posedge clk);
            #1;
            s_req_valid = 1'b0;
            exp_q.push_back({24'b0, x[i]});
            lat = -1;
            r = '0;
            for (int c = 1; c <= 30; c++) begin
                @(negedge clk);
                if (s_resp_valid) begin
                    lat = c;
                    r = s_result;
                    break;
                end
                @(posedge clk);
                #1;
            end
            e = exp_q.pop_front();
            n_vec++;
            if ({24'b0, r} !== e || lat != l[i]) begin
                n_err++;
                $display("FAIL xlen8_%0d: got %h lat %0d want %h lat %0d",
                         i, r, lat, e[7:0], l[i]);
            end
            s_resp_ready = 1'b1;
            @(posedge clk);
            #1;
            s_resp_ready = 1'b0;
        end
    endtask

    initial begin
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_funct3   = '0;
        req_op1      = '0;
        req_op2      = '0;
        req_kill     = 1'b0;
        resp_ready   = 1'b0;
        s_req_valid  = 1'b0;
        s_funct3     = '0;
        s_op1        = '0;
        s_op2        = '0;
        s_kill       = 1'b0;
        s_resp_ready = 1'b0;
        test_reset();
        test_mul();
        test_directed();
        test_special();
        test_backpressure();
        test_kill();
        test_rst_abort();
        test_random();
        test_xlen8();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
